// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and forwarding controller for a five-stage pipeline (IF, ID, EXE,
// MEM, WB). A two-entry scoreboard mirrors the destination-register state of
// the instructions in EXE (entry E) and MEM (entry M). The ID-stage sources
// are compared against it to produce operand-forwarding selects, load-use
// stalls, flush bubbles and a global freeze while data memory is busy.
//
// Ports:
//   clk        pipeline clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   id_valid   ID instruction is real (not a bubble)
//   id_rs/rt   ID source register numbers (5 bits each)
//   id_use_rs/rt  ID instruction actually reads rs / rt
//   id_wreg    ID instruction writes a register
//   id_m2reg   ID instruction is a load (result comes from memory)
//   id_dest    ID destination register (5 bits)
//   flush      squash the ID instruction (taken branch/jump)
//   mem_wait   data memory not ready, freeze the pipeline
//   pipe_en    enable for ID/EXE, EXE/MEM and MEM/WB registers
//   pc_we      PC write enable
//   ifid_we    IF/ID write enable
//   bubble     ID/EXE loads a NOP
//   fwda/fwdb  operand selects: 00 regfile, 01 EXE ALU, 10 MEM ALU, 11 MEM load
//   stall_cnt  saturating count of load-use stall cycles (16 bits)

module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_wreg,
  input  logic        id_m2reg,
  input  logic [4:0]  id_dest,
  input  logic        flush,
  input  logic        mem_wait,
  output logic        pipe_en,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        bubble,
  output logic [1:0]  fwda,
  output logic [1:0]  fwdb,
  output logic [15:0] stall_cnt
);

  // Scoreboard entries: E tracks the EXE-stage instruction, M the MEM-stage one.
  logic       e_v, e_wreg, e_m2reg;
  logic [4:0] e_dest;
  logic       m_v, m_wreg, m_m2reg;
  logic [4:0] m_dest;

  logic rs_live, rt_live;
  logic e_hit_rs, e_hit_rt, m_hit_rs, m_hit_rt;
  logic lu_rs, lu_rt, lu;

  // Forward select for one source. E is the newest producer, so it wins over M.
  // When E is a load the select is irrelevant (the ID instruction is stalled).
  function automatic logic [1:0] fwd_sel(input logic e_hit, input logic e_load,
                                         input logic m_hit, input logic m_load);
    logic [1:0] sel;
    sel = 2'b00;
    if (e_hit)      sel = e_load ? 2'b00 : 2'b01;
    else if (m_hit) sel = m_load ? 2'b11 : 2'b10;
    return sel;
  endfunction

  // Source-versus-scoreboard comparison. Register 0 is hard-wired to zero and
  // never creates a dependency.
  always_comb begin
    rs_live  = id_valid && id_use_rs && (id_rs != 5'd0);
    rt_live  = id_valid && id_use_rt && (id_rt != 5'd0);
    e_hit_rs = rs_live && e_v && e_wreg && (e_dest == id_rs);
    e_hit_rt = rt_live && e_v && e_wreg && (e_dest == id_rt);
    m_hit_rs = rs_live && m_v && m_wreg && (m_dest == id_rs);
    m_hit_rt = rt_live && m_v && m_wreg && (m_dest == id_rt);
    lu_rs    = e_hit_rs && e_m2reg;
    lu_rt    = e_hit_rt && e_m2reg;
    lu       = lu_rs || lu_rt;
    fwda     = fwd_sel(e_hit_rs, e_m2reg, m_hit_rs, m_m2reg);
    fwdb     = fwd_sel(e_hit_rt, e_m2reg, m_hit_rt, m_m2reg);
  end

  // Pipeline control. A memory wait freezes everything; a flush squashes the
  // ID instruction even when it would have stalled, since its operands are
  // never needed.
  always_comb begin
    pipe_en = 1'b1;
    pc_we   = 1'b1;
    ifid_we = 1'b1;
    bubble  = 1'b0;
    if (mem_wait) begin
      pipe_en = 1'b0;
      pc_we   = 1'b0;
      ifid_we = 1'b0;
    end else if (flush) begin
      bubble  = 1'b1;
    end else if (lu) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      bubble  = 1'b1;
    end
  end

  // Scoreboard shift. It follows the ID/EXE and EXE/MEM registers, so it holds
  // during a memory wait and records an invalid entry whenever a bubble is
  // inserted into ID/EXE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_v     <= 1'b0;
      e_wreg  <= 1'b0;
      e_m2reg <= 1'b0;
      e_dest  <= 5'd0;
      m_v     <= 1'b0;
      m_wreg  <= 1'b0;
      m_m2reg <= 1'b0;
      m_dest  <= 5'd0;
    end else if (!mem_wait) begin
      m_v     <= e_v;
      m_wreg  <= e_wreg;
      m_m2reg <= e_m2reg;
      m_dest  <= e_dest;
      e_v     <= id_valid && !bubble;
      e_wreg  <= id_wreg;
      e_m2reg <= id_m2reg;
      e_dest  <= id_dest;
    end
  end

  // Load-use stall counter. Only stalls that actually take effect are counted;
  // flushed or frozen cycles are not. The count saturates instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if (lu && !flush && !mem_wait && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Self-checking bench for pipeline_hazard_ctrl: a table of two-producer
// scenarios with expected forwarding/control outputs, plus hand-written
// sequences for reset, load-use, flush, memory wait and counter saturation.

module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt;
  logic        id_use_rs, id_use_rt;
  logic        id_wreg, id_m2reg;
  logic [4:0]  id_dest;
  logic        flush, mem_wait;
  logic        pipe_en, pc_we, ifid_we, bubble;
  logic [1:0]  fwda, fwdb;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .id_wreg   (id_wreg),
    .id_m2reg  (id_m2reg),
    .id_dest   (id_dest),
    .flush     (flush),
    .mem_wait  (mem_wait),
    .pipe_en   (pipe_en),
    .pc_we     (pc_we),
    .ifid_we   (ifid_we),
    .bubble    (bubble),
    .fwda      (fwda),
    .fwdb      (fwdb),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // One scenario: older producer (ends up in M), newer producer (ends up in E),
  // then the ID instruction under test with its expected outputs.
  typedef struct {
    string      name;
    logic       o_valid, o_wreg, o_m2reg;
    logic [4:0] o_dest;
    logic       n_valid, n_wreg, n_m2reg;
    logic [4:0] n_dest;
    logic       valid, use_rs, use_rt;
    logic [4:0] rs, rt;
    logic       fl, mw;
    logic       care_a, care_b;
    logic [1:0] exp_a, exp_b;
    logic       exp_pipe, exp_pc, exp_ifid, exp_bub;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction that only produces a result, and clock it into E.
  task automatic issue(input logic v, input logic w, input logic ld, input logic [4:0] d);
    id_valid  = v;
    id_wreg   = w;
    id_m2reg  = ld;
    id_dest   = d;
    id_use_rs = 1'b0;
    id_use_rt = 1'b0;
    id_rs     = 5'd0;
    id_rt     = 5'd0;
    flush     = 1'b0;
    mem_wait  = 1'b0;
    tick();
  endtask

  // Present a consumer instruction in ID (its own destination is irrelevant).
  task automatic setId(input logic v, input logic urs, input logic urt,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic fl, input logic mw);
    id_valid  = v;
    id_use_rs = urs;
    id_use_rt = urt;
    id_rs     = rs;
    id_rt     = rt;
    id_wreg   = 1'b0;
    id_m2reg  = 1'b0;
    id_dest   = 5'd0;
    flush     = fl;
    mem_wait  = mw;
  endtask

  task automatic doReset();
    rst = 1'b1;
    setId(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    issue(v.o_valid, v.o_wreg, v.o_m2reg, v.o_dest);
    issue(v.n_valid, v.n_wreg, v.n_m2reg, v.n_dest);
    setId(v.valid, v.use_rs, v.use_rt, v.rs, v.rt, v.fl, v.mw);
    #1;
  endtask

  initial begin
    // name, older{v,w,ld,d}, newer{v,w,ld,d}, id{v,urs,urt,rs,rt,fl,mw},
    // care{a,b}, exp{a,b}, exp{pipe,pc,ifid,bubble}
    vecs[0]  = '{"e_alu_rs",      0,0,0,5'd0,  1,1,0,5'd3,  1,1,0,5'd3,5'd0,0,0,  1,1,2'b01,2'b00, 1,1,1,0};
    vecs[1]  = '{"m_alu_rt",      1,1,0,5'd3,  0,0,0,5'd0,  1,0,1,5'd0,5'd3,0,0,  1,1,2'b00,2'b10, 1,1,1,0};
    vecs[2]  = '{"m_load_rs",     1,1,1,5'd4,  0,0,0,5'd0,  1,1,0,5'd4,5'd0,0,0,  1,1,2'b11,2'b00, 1,1,1,0};
    vecs[3]  = '{"both_r5",       1,1,0,5'd5,  1,1,0,5'd5,  1,1,1,5'd5,5'd5,0,0,  1,1,2'b01,2'b01, 1,1,1,0};
    vecs[4]  = '{"e_load_r5",     1,1,0,5'd5,  1,1,1,5'd5,  1,1,0,5'd5,5'd0,0,0,  0,1,2'b00,2'b00, 1,0,0,1};
    vecs[5]  = '{"dest_r0",       0,0,0,5'd0,  1,1,0,5'd0,  1,1,1,5'd0,5'd0,0,0,  1,1,2'b00,2'b00, 1,1,1,0};
    vecs[6]  = '{"e_no_wreg",     0,0,0,5'd0,  1,0,0,5'd6,  1,1,0,5'd6,5'd0,0,0,  1,1,2'b00,2'b00, 1,1,1,0};
    vecs[7]  = '{"rs_unused",     0,0,0,5'd0,  1,1,1,5'd7,  1,0,0,5'd7,5'd7,0,0,  1,1,2'b00,2'b00, 1,1,1,0};
    vecs[8]  = '{"id_invalid",    0,0,0,5'd0,  1,1,1,5'd7,  0,1,1,5'd7,5'd7,0,0,  1,1,2'b00,2'b00, 1,1,1,0};
    vecs[9]  = '{"lu_flush",      0,0,0,5'd0,  1,1,1,5'd8,  1,0,1,5'd0,5'd8,1,0,  1,0,2'b00,2'b00, 1,1,1,1};
    vecs[10] = '{"lu_wait_flush", 0,0,0,5'd0,  1,1,1,5'd8,  1,1,0,5'd8,5'd0,1,1,  0,1,2'b00,2'b00, 0,0,0,0};
    vecs[11] = '{"e_invalid",     0,0,0,5'd0,  0,1,0,5'd9,  1,1,0,5'd9,5'd0,0,0,  1,1,2'b00,2'b00, 1,1,1,0};
    vecs[12] = '{"e_over_m_load", 1,1,1,5'd10, 1,1,0,5'd10, 1,1,1,5'd11,5'd10,0,0, 1,1,2'b00,2'b01, 1,1,1,0};
    vecs[13] = '{"m_e_split",     1,1,0,5'd12, 1,1,0,5'd13, 1,1,1,5'd12,5'd13,0,0, 1,1,2'b10,2'b01, 1,1,1,0};

    // Asynchronous reset: outputs must be in reset state before any clock edge.
    rst = 1'b1;
    setId(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    #2;
    checkOutput("rst.pipe_en", 16'(pipe_en), 16'd1);
    checkOutput("rst.pc_we", 16'(pc_we), 16'd1);
    checkOutput("rst.ifid_we", 16'(ifid_we), 16'd1);
    checkOutput("rst.bubble", 16'(bubble), 16'd0);
    checkOutput("rst.fwda", 16'(fwda), 16'd0);
    checkOutput("rst.fwdb", 16'(fwdb), 16'd0);
    checkOutput("rst.stall_cnt", stall_cnt, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] load-use stall then forward from MEM");
    issue(1'b1, 1'b1, 1'b1, 5'd2);
    setId(1'b1, 1'b1, 1'b0, 5'd2, 5'd0, 1'b0, 1'b0);
    #1;
    checkOutput("lu.pc_we", 16'(pc_we), 16'd0);
    checkOutput("lu.ifid_we", 16'(ifid_we), 16'd0);
    checkOutput("lu.bubble", 16'(bubble), 16'd1);
    checkOutput("lu.pipe_en", 16'(pipe_en), 16'd1);
    tick();
    checkOutput("lu_next.stall_cnt", stall_cnt, 16'd1);
    checkOutput("lu_next.fwda", 16'(fwda), 16'b11);
    checkOutput("lu_next.pc_we", 16'(pc_we), 16'd1);
    checkOutput("lu_next.bubble", 16'(bubble), 16'd0);

    $display("[TB] reset asserted during a stall");
    issue(1'b1, 1'b1, 1'b1, 5'd2);
    setId(1'b1, 1'b1, 1'b0, 5'd2, 5'd0, 1'b0, 1'b0);
    #1;
    checkOutput("pre_rst.bubble", 16'(bubble), 16'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst.bubble", 16'(bubble), 16'd0);
    checkOutput("mid_rst.pc_we", 16'(pc_we), 16'd1);
    checkOutput("mid_rst.stall_cnt", stall_cnt, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] load-use together with flush");
    issue(1'b1, 1'b1, 1'b1, 5'd2);
    setId(1'b1, 1'b1, 1'b0, 5'd2, 5'd0, 1'b1, 1'b0);
    #1;
    checkOutput("lu_flush.bubble", 16'(bubble), 16'd1);
    checkOutput("lu_flush.pc_we", 16'(pc_we), 16'd1);
    checkOutput("lu_flush.ifid_we", 16'(ifid_we), 16'd1);
    tick();
    checkOutput("lu_flush.stall_cnt", stall_cnt, 16'd0);
    setId(1'b1, 1'b1, 1'b0, 5'd2, 5'd0, 1'b0, 1'b0);
    #1;
    checkOutput("after_flush.fwda", 16'(fwda), 16'b11);
    checkOutput("after_flush.bubble", 16'(bubble), 16'd0);

    $display("[TB] load-use together with mem_wait");
    doReset();
    issue(1'b1, 1'b1, 1'b1, 5'd2);
    setId(1'b1, 1'b1, 1'b0, 5'd2, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("wait.pipe_en", 16'(pipe_en), 16'd0);
      checkOutput("wait.pc_we", 16'(pc_we), 16'd0);
      checkOutput("wait.ifid_we", 16'(ifid_we), 16'd0);
      checkOutput("wait.bubble", 16'(bubble), 16'd0);
      checkOutput("wait.stall_cnt", stall_cnt, 16'd0);
      tick();
    end
    mem_wait = 1'b0;
    #1;
    checkOutput("wait_done.bubble", 16'(bubble), 16'd1);
    checkOutput("wait_done.pc_we", 16'(pc_we), 16'd0);
    tick();
    checkOutput("wait_done.stall_cnt", stall_cnt, 16'd1);
    checkOutput("wait_done.fwda", 16'(fwda), 16'b11);
    checkOutput("wait_done.pc_we", 16'(pc_we), 16'd1);

    $display("[TB] vector table");
    doReset();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      if (vecs[i].care_a) checkOutput({vecs[i].name, ".fwda"}, 16'(fwda), 16'(vecs[i].exp_a));
      if (vecs[i].care_b) checkOutput({vecs[i].name, ".fwdb"}, 16'(fwdb), 16'(vecs[i].exp_b));
      checkOutput({vecs[i].name, ".pipe_en"}, 16'(pipe_en), 16'(vecs[i].exp_pipe));
      checkOutput({vecs[i].name, ".pc_we"}, 16'(pc_we), 16'(vecs[i].exp_pc));
      checkOutput({vecs[i].name, ".ifid_we"}, 16'(ifid_we), 16'(vecs[i].exp_ifid));
      checkOutput({vecs[i].name, ".bubble"}, 16'(bubble), 16'(vecs[i].exp_bub));
    end

    // A real stall always empties E, so a load is held in E to get a stall on
    // every cycle and reach saturation.
    $display("[TB] stall counter saturation");
    doReset();
    force dut.e_v = 1'b1;
    force dut.e_wreg = 1'b1;
    force dut.e_m2reg = 1'b1;
    force dut.e_dest = 5'd2;
    setId(1'b1, 1'b1, 1'b0, 5'd2, 5'd0, 1'b0, 1'b0);
    #1;
    checkOutput("sat.pc_we", 16'(pc_we), 16'd0);
    repeat (65534) @(posedge clk);
    #1;
    checkOutput("sat.stall_cnt_fffe", stall_cnt, 16'hFFFE);
    tick();
    checkOutput("sat.stall_cnt_ffff", stall_cnt, 16'hFFFF);
    tick();
    tick();
    checkOutput("sat.stall_cnt_hold", stall_cnt, 16'hFFFF);
    release dut.e_v;
    release dut.e_wreg;
    release dut.e_m2reg;
    release dut.e_dest;
    doReset();
    checkOutput("final.stall_cnt", stall_cnt, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
